// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: synchronous instruction memory with a valid/ready fetch
// port, a one-entry registered response buffer and a run-time program-load
// mode. Misaligned or out-of-range fetches return NOP_INSTR with error flags.
module imem_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 512,
  parameter string                 INIT_FILE  = "",
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  // fetch response
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_instr,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [1:0]            resp_err,
  // program load
  input  logic                  load_mode,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_busy,
  output logic [ADDR_WIDTH-1:0] load_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_instr_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  logic [1:0]            resp_err_q;
  logic [ADDR_WIDTH-1:0] load_count_q;

  logic [ADDR_WIDTH-3:0] req_word;
  logic                  req_misaligned;
  logic                  req_oor;
  logic                  accept;
  logic                  resp_take;
  logic [ADDR_WIDTH-3:0] load_word;
  logic                  load_in_range;
  logic                  load_wr;
  logic                  load_enter;
  logic                  unused_load_lsbs;

  // Address decode and handshake qualification.
  always_comb begin
    req_word         = req_addr[ADDR_WIDTH-1:2];
    req_misaligned   = (req_addr[1:0] != 2'b00);
    req_oor          = (req_word >= DEPTH_W);
    load_word        = load_addr[ADDR_WIDTH-1:2];
    load_in_range    = (load_word < DEPTH_W);
    unused_load_lsbs = ^load_addr[1:0];
    resp_take        = resp_valid_q && resp_ready;
    req_ready        = (state_q == ST_RUN) && !load_mode && (!resp_valid_q || resp_ready);
    accept           = req_valid && req_ready;
    load_wr          = (state_q == ST_LOAD) && load_we && load_in_range && !reset;
    load_enter       = (state_q != ST_LOAD) && (state_d == ST_LOAD);
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic for RUN / DRAIN / LOAD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (load_mode) state_d = (!resp_valid_q || resp_ready) ? ST_LOAD : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!load_mode)     state_d = ST_RUN;
        else if (resp_take) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!load_mode) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Response buffer: capture on accept (which may coincide with the consumer
  // taking the previous entry), otherwise empty on take.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_instr_q <= NOP_INSTR;
      resp_addr_q  <= '0;
      resp_err_q   <= '0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_addr_q  <= req_addr;
      resp_err_q   <= {req_oor, req_misaligned};
      if (req_misaligned || req_oor) resp_instr_q <= NOP_INSTR;
      else                           resp_instr_q <= mem[req_word[IDX_W-1:0]];
    end else if (resp_take) begin
      resp_valid_q <= 1'b0;
    end
  end

  // Program-load writes; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (load_wr) mem[load_word[IDX_W-1:0]] <= load_data;
  end

  // Accepted-write counter, cleared on each entry to LOAD and held after exit.
  always_ff @(posedge clk) begin
    if (reset)           load_count_q <= '0;
    else if (load_enter) load_count_q <= '0;
    else if (load_wr)    load_count_q <= load_count_q + ADDR_WIDTH'(1);
  end

  // Output mapping.
  always_comb begin
    resp_valid = resp_valid_q;
    resp_instr = resp_instr_q;
    resp_addr  = resp_addr_q;
    resp_err   = resp_err_q;
    load_count = load_count_q;
    load_busy  = (state_q != ST_RUN);
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: table-driven fetch vectors,
// directed multi-cycle sequences and a randomized scoreboard run.
module tb_imem_fetch_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 512;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_instr, resp_addr;
  logic [1:0]  resp_err;
  logic        load_mode, load_we;
  logic [31:0] load_addr, load_data;
  logic        load_busy;
  logic [31:0] load_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  err;
  } vec_t;

  vec_t tbl [9];
  vec_t exp_q [$];

  imem_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .INIT_FILE(""),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_addr(resp_addr), .resp_err(resp_err),
    .load_mode(load_mode), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_busy(load_busy), .load_count(load_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t expect_of(input logic [31:0] a);
    vec_t v;
    v.addr   = a;
    v.err[0] = (a[1:0] != 2'b00);
    v.err[1] = ((a >> 2) >= DEPTH);
    v.instr  = (v.err != 2'b00) ? NOP : model_mem[a >> 2];
    return v;
  endfunction

  task automatic check_resp(input string name, input vec_t e);
    chk({name, "_valid"}, resp_valid, 1'b1);
    chk({name, "_instr"}, resp_instr, e.instr);
    chk({name, "_addr"}, resp_addr, e.addr);
    chk({name, "_err"}, resp_err, e.err);
  endtask

  task automatic fetch1(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    #1;
    chk("fetch_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0; resp_ready = 1'b1; load_mode = 1'b0; load_we = 1'b0;
    tick();
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
    if ((a >> 2) < DEPTH) model_mem[a >> 2] = d;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    load_mode = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;

    tbl[0] = '{32'h0000_0000, 32'hA500_0000, 2'b00};
    tbl[1] = '{32'h0000_0004, 32'hA500_0001, 2'b00};
    tbl[2] = '{32'h0000_0008, 32'hA500_0002, 2'b00};
    tbl[3] = '{32'h0000_07FC, 32'hA500_01FF, 2'b00};
    tbl[4] = '{32'h0000_0006, 32'h0000_0013, 2'b01};
    tbl[5] = '{32'h0000_0800, 32'h0000_0013, 2'b10};
    tbl[6] = '{32'h0000_0802, 32'h0000_0013, 2'b11};
    tbl[7] = '{32'hFFFF_FFFC, 32'h0000_0013, 2'b10};
    tbl[8] = '{32'h0000_0001, 32'h0000_0013, 2'b01};

    // Reset state
    tick(); tick();
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_instr", resp_instr, NOP);
    chk("rst_resp_addr", resp_addr, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_load_busy", load_busy, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);

    // Load the full image through program-load mode
    load_mode = 1'b1;
    tick();
    chk("img_busy", load_busy, 1'b1);
    chk("img_count_start", load_count, 0);
    for (int unsigned i = 0; i < DEPTH; i++) load_word(i * 4, 32'hA500_0000 + i);
    chk("img_count", load_count, DEPTH);
    load_mode = 1'b0;
    tick();
    chk("img_exit_busy", load_busy, 1'b0);

    // Table-driven single fetches
    for (int i = 0; i < 9; i++) begin
      fetch1(tbl[i].addr);
      check_resp($sformatf("tbl%0d", i), tbl[i]);
    end
    idle();
    chk("tbl_drained", resp_valid, 1'b0);

    // Back-to-back fetches, one response per cycle
    req_valid = 1'b1; resp_ready = 1'b1; req_addr = 32'h0;
    tick();
    check_resp("b2b0", tbl[0]);
    req_addr = 32'h4;
    tick();
    check_resp("b2b1", tbl[1]);
    req_addr = 32'h8;
    tick();
    check_resp("b2b2", tbl[2]);
    req_valid = 1'b0;
    tick();
    chk("b2b_empty", resp_valid, 1'b0);

    // Backpressure: response held stable, request blocked, released same cycle
    fetch1(32'h4);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req_ready", req_ready, 1'b0);
      check_resp("bp_hold", tbl[1]);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1'b1);
    tick();
    check_resp("bp_next", tbl[2]);
    idle();

    // load_we outside LOAD is ignored
    load_we = 1'b1; load_addr = 32'h14; load_data = 32'hDEAD_BEEF;
    tick();
    load_we = 1'b0;
    fetch1(32'h14);
    check_resp("we_in_run", expect_of(32'h14));
    idle();

    // DRAIN abandoned when load_mode drops before the response is taken
    fetch1(32'hC);
    resp_ready = 1'b0; load_mode = 1'b1;
    tick();
    chk("drain_busy", load_busy, 1'b1);
    load_mode = 1'b0;
    tick();
    chk("abort_busy", load_busy, 1'b0);
    check_resp("abort_resp", expect_of(32'hC));
    idle();

    // DRAIN -> LOAD once the response is taken, then write and read back
    fetch1(32'hC);
    resp_ready = 1'b0; load_mode = 1'b1;
    tick();
    tick();
    #1;
    chk("drain2_busy", load_busy, 1'b1);
    chk("drain2_req_ready", req_ready, 1'b0);
    chk("drain2_valid", resp_valid, 1'b1);
    resp_ready = 1'b1;
    tick();
    chk("load_busy", load_busy, 1'b1);
    chk("load_valid", resp_valid, 1'b0);
    chk("load_count_clr", load_count, 0);
    load_word(32'h10, 32'h0050_0093);
    load_word(32'h1000, 32'h1234_5678);
    chk("load_count1", load_count, 1);
    load_mode = 1'b0;
    tick();
    chk("load_count_hold", load_count, 1);
    fetch1(32'h10);
    check_resp("readback", '{32'h10, 32'h0050_0093, 2'b00});
    idle();

    // Reset discards a pending response
    fetch1(32'h8);
    resp_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_pend_valid", resp_valid, 1'b0);

    // Reset mid-LOAD keeps already-written words
    load_mode = 1'b1;
    tick();
    load_word(32'h20, $urandom());
    load_word(32'h24, $urandom());
    load_word(32'h28, $urandom());
    chk("midload_count", load_count, 3);
    reset = 1'b1; load_mode = 1'b0;
    tick();
    reset = 1'b0;
    chk("midload_busy", load_busy, 1'b0);
    chk("midload_count_rst", load_count, 0);
    chk("midload_valid", resp_valid, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      fetch1(32'h20 + i * 4);
      check_resp("midload_rd", expect_of(32'h20 + i * 4));
    end
    idle();

    // Randomized fetch traffic against the scoreboard
    for (int n = 0; n < 3000; n++) begin
      logic acc, take;
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       req_addr = $urandom();
        1:       req_addr = {20'h0, $urandom_range(0, 4095)};
        default: req_addr = {21'h0, 9'($urandom_range(0, DEPTH - 1)), 2'b00};
      endcase
      load_we   = ($urandom_range(0, 7) == 0);
      load_addr = {21'h0, 9'($urandom_range(0, DEPTH - 1)), 2'b00};
      load_data = $urandom();
      #1;
      chk("rnd_req_ready", req_ready, !resp_valid || resp_ready);
      acc  = req_valid && req_ready;
      take = resp_valid && resp_ready;
      if (take) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_resp", 1'b1, 1'b0);
        else check_resp("rnd", exp_q.pop_front());
      end
      if (acc) exp_q.push_back(expect_of(req_addr));
      tick();
      chk("rnd_valid", resp_valid, exp_q.size() != 0);
    end
    load_we = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
